readout_frame_packer: RTL

- Upstream neighbour of the 128-bit parallel-to-serial output stage.
- Collects a stream of narrow pixel/ADC samples into fixed 128-bit frames, each with a sync word and a sequence number.
- Holds each completed frame stable in an output register until the serializer takes it with a valid/ready handshake.
- Assembles the next frame while the current one waits, for gap-free readout.

---
 rtl/readout_pkg.sv | 22 ++
 rtl/frame_holding_reg.sv | 53 +++++
 rtl/readout_frame_packer.sv | 107 ++++++++++
 3 files changed

// File: rtl/readout_pkg.sv
// Shared frame layout for the readout packer: sync/seq header positions, header struct, slot count.
// The 16-bit header sits in the top of every frame; data slots fill the rest, MSB first.
package readout_pkg;

  localparam logic [7:0] SYNC_WORD_DEF = 8'hA5;
  localparam int         HDR_WIDTH     = 16;

  localparam int SYNC_MSB = 127;
  localparam int SYNC_LSB = 120;
  localparam int SEQ_MSB  = 119;
  localparam int SEQ_LSB  = 112;

  typedef struct packed {
    logic [7:0] sync;
    logic [7:0] seq;
  } frame_hdr_t;

  function automatic int calc_nslot(input int frame_w, input int sample_w);
    return (frame_w - HDR_WIDTH) / sample_w;
  endfunction

endpackage

// File: rtl/frame_holding_reg.sv
// Valid/ready output register: a load lands next edge if empty or transferring, otherwise it is dropped.
// Dropping a load sets a sticky overflow flag; the held frame is never disturbed while waiting.
module frame_holding_reg #(
  parameter int W = 128
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         load_vld_i,
  input  logic [W-1:0] load_dat_i,
  input  logic         rdy_i,
  output logic [W-1:0] dat_o,
  output logic         vld_o,
  output logic         ovf_o
);

  logic [W-1:0] dat_q, dat_d;
  logic         vld_q, vld_d;
  logic         ovf_q, ovf_d;
  logic         xfer;

  always_comb begin
    xfer  = vld_q && rdy_i;
    dat_d = dat_q;
    vld_d = vld_q && !xfer;
    ovf_d = ovf_q;
    if (load_vld_i) begin
      // A transfer on the same edge frees the register, so the new frame loads with no bubble.
      if (!vld_q || xfer) begin
        dat_d = load_dat_i;
        vld_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      dat_q <= '0;
      vld_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      dat_q <= dat_d;
      vld_q <= vld_d;
      ovf_q <= ovf_d;
    end
  end

  assign dat_o = dat_q;
  assign vld_o = vld_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/readout_frame_packer.sv
// Packs narrow samples into sync+seq headed frames; completion in cycle N is visible in cycle N+1.
// No input backpressure; a frame completing while the output is held is dropped. READOUT_CHECKSUM_EN puts an XOR in the last slot.
module readout_frame_packer
  import readout_pkg::*;
#(
  parameter int         SAMPLE_WIDTH = 8,
  parameter int         FRAME_WIDTH  = 128,
  parameter logic [7:0] SYNC_WORD    = SYNC_WORD_DEF,
  parameter int         SEQ_WIDTH    = 8
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    sample_valid,
  input  logic [SAMPLE_WIDTH-1:0] sample_data,
  input  logic                    flush,
  output logic [FRAME_WIDTH-1:0]  frame_data,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic                    overflow
);

  localparam int NSLOT     = calc_nslot(FRAME_WIDTH, SAMPLE_WIDTH);
  localparam int HDR_W     = SYNC_MSB - SEQ_LSB + 1;
  localparam int PAYLOAD_W = FRAME_WIDTH - HDR_W;
  localparam int CNT_W     = $clog2(NSLOT);
`ifdef READOUT_CHECKSUM_EN
  localparam int NDATA = NSLOT - 1;
`else
  localparam int NDATA = NSLOT;
`endif

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PAYLOAD_W-1:0]    asm_q, asm_d;
  logic [SEQ_WIDTH-1:0]    seq_q, seq_d;
  logic [PAYLOAD_W-1:0]    asm_wr;
  logic [PAYLOAD_W-1:0]    payload;
  logic                    complete;
  frame_hdr_t              hdr;
  logic [FRAME_WIDTH-1:0]  frame_nxt;
`ifdef READOUT_CHECKSUM_EN
  logic [SAMPLE_WIDTH-1:0] cks;
`endif

  always_comb begin
    asm_wr = asm_q;
    for (int i = 0; i < NDATA; i++) begin
      if (sample_valid && cnt_q == CNT_W'(i)) begin
        asm_wr[PAYLOAD_W-1-i*SAMPLE_WIDTH -: SAMPLE_WIDTH] = sample_data;
      end
    end

    // A same-cycle sample counts, so flush with an empty buffer plus a sample still closes a frame.
    complete = (sample_valid && cnt_q == CNT_W'(NDATA-1)) ||
               (flush && (sample_valid || cnt_q != '0));

    payload = asm_wr;
`ifdef READOUT_CHECKSUM_EN
    cks = '0;
    for (int i = 0; i < NSLOT-1; i++) begin
      cks = cks ^ asm_wr[PAYLOAD_W-1-i*SAMPLE_WIDTH -: SAMPLE_WIDTH];
    end
    payload[SAMPLE_WIDTH-1:0] = cks;
`endif

    hdr.sync  = SYNC_WORD;
    hdr.seq   = 8'(seq_q);
    frame_nxt = {hdr, payload};

    cnt_d = cnt_q;
    asm_d = asm_wr;
    seq_d = seq_q;
    if (complete) begin
      // Buffer clears on completion so a later flush pads with zeros.
      cnt_d = '0;
      asm_d = '0;
      seq_d = seq_q + SEQ_WIDTH'(1);
    end else if (sample_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q <= '0;
      asm_q <= '0;
      seq_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
      seq_q <= seq_d;
    end
  end

  frame_holding_reg #(
    .W (FRAME_WIDTH)
  ) u_hold (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .load_vld_i (complete),
    .load_dat_i (frame_nxt),
    .rdy_i      (frame_ready),
    .dat_o      (frame_data),
    .vld_o      (frame_valid),
    .ovf_o      (overflow)
  );

endmodule
